// File: rtl/disp_scan_sel.sv
// disp_scan_sel: registered display source selector with manual and masked auto-scan modes
module disp_scan_sel #(
  parameter int          NCH     = 19,
  parameter int          DW      = 64,
  parameter int          DWELL   = 50_000_000,
  parameter logic [63:0] RST_NUM = 64'h0123456789ABCDEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              EN,
  input  logic              scan,
  input  logic [4:0]        Disp_sel,
  input  logic [NCH*DW-1:0] disp_bus,
  input  logic [NCH-1:0]    narrow_mask,
  input  logic [NCH-1:0]    blink_mask,
  input  logic [NCH-1:0]    scan_mask,
  input  logic [4*NCH-1:0]  point_in,
  input  logic [3:0]        blink_in,
  output logic [DW-1:0]     Disp_num,
  output logic [3:0]        point_out,
  output logic [3:0]        blink_out,
  output logic [4:0]        cur_ch,
  output logic              ch_chg,
  output logic              sel_err
);
  localparam int CW = $clog2(DWELL);
  localparam logic [DW-1:0] NARROW_KEEP = {{(DW/2){1'b0}}, {(DW-DW/2){1'b1}}};

  logic [CW-1:0] r_cnt;
  logic [4:0]    r_cur_ch;
  logic [DW-1:0] r_num;
  logic [3:0]    r_point;
  logic [3:0]    r_blink;
  logic          r_chg;
  logic          r_err;

  logic [31:0]   w_smask;
  logic [31:0]   w_nmask;
  logic [31:0]   w_bmask;
  logic [4:0]    w_scan_nxt;
  logic          w_valid;
  logic          w_wrap;
  logic          w_upd;
  logic [4:0]    w_ch;
  logic [DW-1:0] w_data;

  // channel index c+i reduced modulo NCH (both operands already below NCH)
  function automatic logic [4:0] f_add(input logic [4:0] c, input int i);
    logic [5:0] s;
    s = {1'b0, c} + 6'(i);
    return (s >= 6'(NCH)) ? 5'(s - 6'(NCH)) : s[4:0];
  endfunction

  assign w_smask = 32'(scan_mask);
  assign w_nmask = 32'(narrow_mask);
  assign w_bmask = 32'(blink_mask);
  assign w_valid = {1'b0, Disp_sel} < 6'(NCH);
  assign w_wrap  = r_cnt == CW'(DWELL - 1);
  assign w_upd   = scan | w_valid;
  assign w_ch    = scan ? (w_wrap ? w_scan_nxt : r_cur_ch) : (w_valid ? Disp_sel : r_cur_ch);
  assign w_data  = disp_bus[w_ch*DW +: DW] & (w_nmask[w_ch] ? NARROW_KEEP : {DW{1'b1}});

  // nearest enabled channel above cur_ch, cyclic; lowest offset wins, own channel stays if none
  always_comb begin
    w_scan_nxt = r_cur_ch;
    for (int i = NCH - 1; i >= 1; i--)
      if (w_smask[f_add(r_cur_ch, i)]) w_scan_nxt = f_add(r_cur_ch, i);
  end

  // state and registered outputs; manual mode keeps the dwell counter parked at 0
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_cur_ch <= '0;
      r_num    <= DW'(RST_NUM);
      r_point  <= 4'b1111;
      r_blink  <= 4'b0000;
      r_chg    <= 1'b0;
      r_err    <= 1'b0;
    end else if (EN) begin
      r_cnt    <= (scan && !w_wrap) ? r_cnt + CW'(1) : '0;
      r_cur_ch <= w_ch;
      r_chg    <= w_ch != r_cur_ch;
      r_err    <= !scan && !w_valid;
      if (w_upd) begin
        r_num   <= w_data;
        r_point <= point_in[w_ch*4 +: 4];
        r_blink <= w_bmask[w_ch] ? blink_in : 4'b0000;
      end
    end else begin
      r_chg <= 1'b0;
    end
  end

  assign Disp_num  = r_num;
  assign point_out = r_point;
  assign blink_out = r_blink;
  assign cur_ch    = r_cur_ch;
  assign ch_chg    = r_chg;
  assign sel_err   = r_err;
endmodule

// File: doc/disp_scan_sel.md
DISP_SCAN_SEL -- requirements
Module: disp_scan_sel

Interface
REQ-001 Parameter NCH, default 19: number of display sources, legal range 2..32.
REQ-002 Parameter DW, default 64: width of each source and of Disp_num.
REQ-003 Parameter DWELL, default 50_000_000: clocks spent on each channel in scan mode, minimum 2.
REQ-004 Parameter RST_NUM, default 64'h0123456789ABCDEF: Disp_num value after reset, truncated to DW.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, synchronous and active-high.
REQ-007 EN  in  1  update enable; 0 freezes all state and outputs.
REQ-008 scan  in  1  mode select: 0 = manual, 1 = auto-scan.
REQ-009 Disp_sel  in  5  manual channel index.
REQ-010 disp_bus  in  NCH*DW  flattened sources; channel k occupies bits [k*DW +: DW].
REQ-011 narrow_mask  in  NCH  bit k=1: channel k is half-width, so its upper DW/2 bits are forced to 0.
REQ-012 blink_mask  in  NCH  bit k=1: blink_in is passed through while channel k is shown.
REQ-013 scan_mask  in  NCH  bit k=1: channel k takes part in auto-scan.
REQ-014 point_in  in  4*NCH  per-channel decimal-point pattern; channel k uses bits [4k+:4].
REQ-015 blink_in  in  4  blink pattern.
REQ-016 Disp_num  out  DW  registered selected value.
REQ-017 point_out  out  4  registered point pattern.
REQ-018 blink_out  out  4  registered blink pattern.
REQ-019 cur_ch  out  5  channel currently driving the outputs.
REQ-020 ch_chg  out  1  one-cycle pulse in the cycle cur_ch takes a new value.
REQ-021 sel_err  out  1  registered; 1 while manual Disp_sel >= NCH.

Function
REQ-022 All outputs SHALL be registered, with exactly one cycle of latency from the inputs of the selected channel to the outputs.
REQ-023 On each EN=1 cycle, the outputs SHALL be:
- Disp_num = disp_bus[ch], with the upper DW/2 bits cleared if narrow_mask[ch]=1
- point_out = point_in[4ch+:4]
- blink_out = blink_mask[ch] ? blink_in : 4'b0000
- where ch is the next value of cur_ch.
REQ-024 Manual mode, Disp_sel < NCH: cur_ch SHALL take the value Disp_sel, sel_err SHALL be 0, and the dwell counter SHALL be held at 0.
REQ-025 Manual mode, Disp_sel >= NCH: cur_ch and all data outputs SHALL hold their previous values, and sel_err SHALL be 1.
REQ-026 Scan mode: the dwell counter SHALL increment on each EN=1 cycle and wrap at DWELL-1.
REQ-027 On a dwell wrap, cur_ch SHALL advance to the next index above cur_ch with scan_mask=1, searching cyclically and wrapping from NCH-1 to 0.
REQ-028 While the dwell counter is not wrapping, cur_ch SHALL be unchanged, but the data outputs SHALL still refresh from the live inputs.
REQ-029 If scan_mask is all zero, cur_ch SHALL stay put.
REQ-030 If cur_ch is the only set bit of scan_mask, cur_ch SHALL stay put and ch_chg SHALL stay 0.
REQ-031 The transition manual->scan SHALL clear the dwell counter and start dwelling on the current cur_ch.
REQ-032 The transition scan->manual SHALL take effect on the same edge; the manual rules apply immediately.
REQ-033 In scan mode sel_err SHALL be 0.
REQ-034 ch_chg SHALL be 1 only for the single cycle after an edge on which cur_ch changed value.
REQ-035 EN=0 SHALL hold the counter, cur_ch and all outputs, and SHALL force ch_chg to 0.
REQ-036 When rst=1 and EN=1 in the same cycle, rst SHALL take priority.

Reset
REQ-037 With rst=1 at a clock edge, the block SHALL set Disp_num=RST_NUM, point_out=4'b1111, blink_out=4'b0000, cur_ch=0, ch_chg=0, sel_err=0 and dwell counter=0, regardless of EN.
REQ-038 A reset asserted mid-scan SHALL abandon the dwell and restart from channel 0 once rst falls.

Verification
REQ-039 Reset: assert rst for 2 clocks -> Disp_num=64'h0123456789ABCDEF, point_out=4'hF, blink_out=0, cur_ch=0.
REQ-040 Manual narrow channel: NCH=19, manual, Disp_sel=6, narrow_mask[6]=1, channel 6 = 64'hFFFF_FFFF_1234_5678 -> one cycle later Disp_num=64'h0000_0000_1234_5678, cur_ch=6, ch_chg pulses once.
REQ-041 Out-of-range select: Disp_sel=25 after Disp_sel=3 -> outputs hold channel-3 data, cur_ch=3, sel_err=1; Disp_sel=4 -> sel_err=0, cur_ch=4.
REQ-042 Scan with mask: DWELL=4, scan_mask=19'b100_0000_0000_0000_0101, start at ch 0 -> cur_ch sequence 0,2,18,0, each held 4 cycles, ch_chg pulses at each change.
REQ-043 Blink gating: blink_mask[1]=1, blink_mask[2]=0, blink_in=4'b1010 -> blink_out=4'b1010 on channel 1 and 4'b0000 on channel 2.
REQ-044 Freeze and priority: EN=0 for 10 cycles mid-scan -> no change on any output; EN=1 and rst=1 together -> reset values.
